map_rle_loader: RTL and testbench
=================================

Name: map_rle_loader

Overview:
- Write-side counterpart to the map tile renderer. It fills the 160x90 map tile RAM that the renderer reads every frame.
- Accepts a run-length-encoded byte stream over a valid/ready handshake, sourced from level select or UART.
- Expands each run into single-cycle tile writes on the RAM write port, in raster order starting at address 0.
- Reports completion and errors, so a new course can be loaded between holes without resynthesising the map ROM image.

Parameters:
- WIDTH, 160, map width in tiles (one tile = 8x8 screen pixels).
- HEIGHT, 90, map height in tiles.
- TILE_BITS, 4, width of one tile code.
- MAX_CODE, 11, highest legal tile code (palette depth 12).

Ports:
- pixel_clk_in  input  1  system clock; all logic on its rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  single-cycle pulse; begins a load at address 0. Ignored unless busy_out=0.
- data_in  input  8  RLE byte: [7:4] = run length minus 1 (runs of 1..16), [3:0] = tile code.
- valid_in  input  1  data_in is valid.
- ready_out  output  1  loader accepts a byte this cycle.
- we_out  output  1  tile RAM write enable.
- waddr_out  output  $clog2(WIDTH*HEIGHT)  tile RAM write address (14 bits at defaults).
- wdata_out  output  TILE_BITS  tile code written.
- busy_out  output  1  a load is in progress (any state except IDLE).
- done_out  output  1  one-cycle pulse at the end of a load, whether or not it succeeded.
- error_out  output  1  sticky flag; cleared by the next accepted start_in.

Behaviour:
- Reset: rst_n_in low asynchronously forces state=IDLE, address=0 and run count=0. All outputs go to 0, with error_out=0.
- States:
  - IDLE: ready_out=0. On start_in: address<=0, error<=0, go to ACCEPT.
  - ACCEPT: ready_out=1. A handshake is valid_in&ready_out at a rising edge.
    - On handshake with code<=MAX_CODE: latch code=data_in[3:0] and count=data_in[7:4], go to EMIT.
    - On handshake with code>MAX_CODE: error<=1, no write, go to DONE.
  - EMIT: ready_out=0, we_out=1, waddr_out=address, wdata_out=code.
    - Each cycle: address++, count--.
    - If address==WIDTH*HEIGHT-1 this cycle: go to DONE. Set error<=1 if count!=0 (run overflowed the map; the excess tiles are dropped).
    - Else if count==0: go to ACCEPT.
  - DONE: done_out=1 for exactly one cycle, then go to IDLE.
- Outputs are driven directly from state and registers; none come from data_in combinationally.
- Latency and throughput:
  - A byte accepted at edge N produces its first write in the cycle following N.
  - A run of L tiles occupies L consecutive cycles.
  - ready_out reasserts in the cycle after the last write, so the best case is one byte per L+1 cycles.
- Address arithmetic: the counter is $clog2(WIDTH*HEIGHT) bits, unsigned. It never wraps, because the last-address check precedes the increment.
- The map must be exactly covered. After the last tile is written the loader finishes; no extra byte is consumed.
- A stream that ends early (valid_in stays low) leaves the loader in ACCEPT indefinitely with busy_out=1. There is no timeout; the host resets or completes the stream.
- start_in while busy_out=1 is ignored.
- start_in in the same cycle as the done_out pulse is ignored; the host waits for busy_out=0.
- Reset mid-load abandons the load. Partially written RAM contents are left as written. The next start restarts at address 0.

Decomposition:
- Package map_pkg holds:
  - MAP_W=160, MAP_H=90, MAP_TILES=14400, TILE_BITS=4.
  - tile_t enum: 0 VOID, 1 WALL, 2 GRASS, 3 ROUGH, 4..11 diagonal wall variants.
  - loader_state_t enum: IDLE, ACCEPT, EMIT, DONE.
- The renderer and this loader share the package.
- Single flat module; no sub-module is warranted (the FSM, run counter and address counter are tightly coupled).

Test Plan:
- Basic run: start, then byte 0x32 -> we_out high 4 consecutive cycles, waddr 0,1,2,3, wdata 2. ready_out low during the run and high on the 5th cycle.
- Full map: 900 bytes of 0xF1 -> exactly 14400 writes of code 1, last waddr 14399, then one done_out pulse with error_out=0 and busy_out=0.
- Illegal code: start, then byte 0x0C -> no we_out, error_out=1, done_out pulse, IDLE. A subsequent start clears error_out.
- Overflow: stream 14398 tiles, then byte 0x32 -> writes at 14398 and 14399 only, error_out=1, done_out pulse. The next offered byte is not accepted.
- Backpressure and gaps:
  - valid_in toggled randomly -> bytes consumed only on handshake cycles.
  - data_in changed during EMIT -> no effect on the current run.
  - Final RAM image matches the reference model.
- Async reset mid-run: rst_n_in low during EMIT, asynchronous to the clock edge -> we_out, busy_out and ready_out drop to 0 immediately. A later start writes from waddr 0 again.

Source files
------------

// File: rtl/map_pkg.sv
// Shared map definitions for the tile renderer and the RLE map loader.
package map_pkg;

    localparam int MAP_W     = 160;
    localparam int MAP_H     = 90;
    localparam int MAP_TILES = MAP_W * MAP_H;
    localparam int TILE_BITS = 4;

    // Tile codes understood by the renderer palette.
    typedef enum logic [3:0] {
        TILE_VOID   = 4'd0,
        TILE_WALL   = 4'd1,
        TILE_GRASS  = 4'd2,
        TILE_ROUGH  = 4'd3,
        TILE_DIAG_0 = 4'd4,
        TILE_DIAG_1 = 4'd5,
        TILE_DIAG_2 = 4'd6,
        TILE_DIAG_3 = 4'd7,
        TILE_DIAG_4 = 4'd8,
        TILE_DIAG_5 = 4'd9,
        TILE_DIAG_6 = 4'd10,
        TILE_DIAG_7 = 4'd11
    } tile_t;

    // Loader control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/map_rle_loader_if.sv
// Byte-stream interface feeding RLE map data into the loader.
//
// Handshake: a byte transfers on a rising clock edge where valid_in and
// ready_out are both high. The source holds data_in while valid_in is high
// and not yet accepted; ready_out never depends combinationally on valid_in
// or data_in.
interface map_rle_loader_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/map_rle_loader.sv
// RLE map loader: expands (run, code) bytes into raster-order tile RAM writes.
module map_rle_loader
    import map_pkg::*;
#(
    parameter int WIDTH     = map_pkg::MAP_W,
    parameter int HEIGHT    = map_pkg::MAP_H,
    parameter int TILE_BITS = map_pkg::TILE_BITS,
    parameter int MAX_CODE  = int'(TILE_DIAG_7),
    localparam int N_TILES  = WIDTH * HEIGHT,
    localparam int AW       = $clog2(N_TILES)
) (
    input  logic                 pixel_clk_in,
    input  logic                 rst_n_in,
    input  logic                 start_in,
    map_rle_loader_if.slave      rle,
    output logic                 we_out,
    output logic [AW-1:0]        waddr_out,
    output logic [TILE_BITS-1:0] wdata_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 error_out,
    output loader_state_t        state_dbg_out
);

    localparam logic [AW-1:0]        LAST_ADDR = AW'(N_TILES - 1);
    localparam logic [TILE_BITS-1:0] MAX_C     = TILE_BITS'(MAX_CODE);

    loader_state_t        state_q, state_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [3:0]           count_q, count_d;
    logic [TILE_BITS-1:0] code_q, code_d;
    logic                 error_q, error_d;

    logic [3:0]           run_in;
    logic [TILE_BITS-1:0] code_in;

    assign run_in  = rle.data_in[7:4];
    assign code_in = rle.data_in[TILE_BITS-1:0];

    // State and datapath registers; reset abandons any load in progress.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
            code_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            code_q  <= code_d;
            error_q <= error_d;
        end
    end

    // Next-state logic: accept one byte, emit its run, stop at the last tile.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        code_d  = code_q;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    addr_d  = '0;
                    error_d = 1'b0;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (rle.valid_in) begin
                    if (code_in > MAX_C) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        code_d  = code_in;
                        count_d = run_in;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                // Last-address check comes before the increment, so the
                // address never wraps; leftover run tiles are dropped.
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                    if (count_q != 4'd0) begin
                        error_d = 1'b1;
                    end
                end else begin
                    addr_d  = addr_q + AW'(1);
                    count_d = count_q - 4'd1;
                    if (count_q == 4'd0) begin
                        state_d = ACCEPT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode registered state only.
    assign rle.ready_out  = (state_q == ACCEPT);
    assign we_out         = (state_q == EMIT);
    assign waddr_out      = addr_q;
    assign wdata_out      = code_q;
    assign busy_out       = (state_q != IDLE);
    assign done_out       = (state_q == DONE);
    assign error_out      = error_q;
    assign state_dbg_out  = state_q;

endmodule

// File: tb/tb_map_rle_loader.sv
// Directed testbench for map_rle_loader.
module tb_map_rle_loader;
    import map_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          we;
    logic [13:0]   waddr;
    logic [3:0]    wdata;
    logic          busy;
    logic          done;
    logic          error;
    loader_state_t state_dbg;

    int err_cnt = 0;
    int chk_cnt = 0;

    map_rle_loader_if rle_if ();

    map_rle_loader dut (
        .pixel_clk_in  (clk),
        .rst_n_in      (rst_n),
        .start_in      (start),
        .rle           (rle_if),
        .we_out        (we),
        .waddr_out     (waddr),
        .wdata_out     (wdata),
        .busy_out      (busy),
        .done_out      (done),
        .error_out     (error),
        .state_dbg_out (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // RAM image and event counters captured from the write port
    logic [3:0]  ram_m [MAP_TILES];
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [13:0] last_waddr = '0;

    always @(negedge clk) begin
        if (we) begin
            if (int'(waddr) < MAP_TILES) ram_m[waddr] = wdata;
            wr_cnt = wr_cnt + 1;
            last_waddr = waddr;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rle_if.valid_in = 1'b0;
        rle_if.data_in  = 8'h00;
        start = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < MAP_TILES; i++) ram_m[i] = 4'hF;
        wr_cnt = 0;
        done_cnt = 0;
        last_waddr = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte and returns at the negedge following its handshake.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rle_if.data_in  = b;
        rle_if.valid_in = 1'b1;
        while (!rle_if.ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (rle_if.ready_out !== 1'b1) begin
            err_cnt++;
            $display("FAIL send_byte_ready: byte %h ready=%b want 1 within 200 cycles", b, rle_if.ready_out);
        end
        @(negedge clk);
        rle_if.valid_in = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL wait_idle: busy=%b want 0 within %0d cycles", busy, budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        chk_cnt++; if (rle_if.ready_out !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %b want 0", rle_if.ready_out); end
        chk_cnt++; if (we !== 1'b0) begin err_cnt++; $display("FAIL reset_we: got %b want 0", we); end
        chk_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        chk_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b want 0", done); end
        chk_cnt++; if (error !== 1'b0) begin err_cnt++; $display("FAIL reset_error: got %b want 0", error); end
        chk_cnt++; if (waddr !== 14'd0) begin err_cnt++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
        chk_cnt++; if (wdata !== 4'd0) begin err_cnt++; $display("FAIL reset_wdata: got %0d want 0", wdata); end
        chk_cnt++; if (state_dbg !== IDLE) begin err_cnt++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    endtask

    task automatic test_basic_run();
        do_reset();
        clear_model();
        pulse_start();
        chk_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy: got %b want 1", busy); end
        chk_cnt++; if (rle_if.ready_out !== 1'b1) begin err_cnt++; $display("FAIL basic_ready_accept: got %b want 1", rle_if.ready_out); end
        rle_if.data_in  = 8'h32;
        rle_if.valid_in = 1'b1;
        @(negedge clk);
        rle_if.valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_cnt++;
            if (we !== 1'b1 || waddr !== 14'(i) || wdata !== 4'd2 || rle_if.ready_out !== 1'b0) begin
                err_cnt++;
                $display("FAIL basic_write%0d: we=%b waddr=%0d wdata=%0d ready=%b want 1 %0d 2 0",
                         i, we, waddr, wdata, rle_if.ready_out, i);
            end
            @(negedge clk);
        end
        chk_cnt++;
        if (rle_if.ready_out !== 1'b1 || we !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_fifth_cycle: ready=%b we=%b want 1 0", rle_if.ready_out, we);
        end
    endtask

    task automatic test_full_map();
        int bad;
        do_reset();
        clear_model();
        pulse_start();
        for (int i = 0; i < 900; i++) send_byte(8'hF1);
        wait_idle(40);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < MAP_TILES; i++) if (ram_m[i] !== 4'd1) bad++;
        chk_cnt++; if (wr_cnt !== 14400) begin err_cnt++; $display("FAIL full_wr_cnt: got %0d want 14400", wr_cnt); end
        chk_cnt++; if (last_waddr !== 14'd14399) begin err_cnt++; $display("FAIL full_last_waddr: got %0d want 14399", last_waddr); end
        chk_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL full_ram_image: %0d tiles differ, want 0", bad); end
        chk_cnt++; if (done_cnt !== 1) begin err_cnt++; $display("FAIL full_done_pulses: got %0d want 1", done_cnt); end
        chk_cnt++; if (error !== 1'b0) begin err_cnt++; $display("FAIL full_error: got %b want 0", error); end
    endtask

    task automatic test_illegal_code();
        do_reset();
        clear_model();
        pulse_start();
        send_byte(8'h0C);
        chk_cnt++;
        if (done !== 1'b1 || error !== 1'b1 || we !== 1'b0) begin
            err_cnt++;
            $display("FAIL illegal_done_cycle: done=%b error=%b we=%b want 1 1 0", done, error, we);
        end
        @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b1 || state_dbg !== IDLE) begin
            err_cnt++;
            $display("FAIL illegal_idle: busy=%b done=%b error=%b state=%0d want 0 0 1 IDLE", busy, done, error, state_dbg);
        end
        chk_cnt++; if (wr_cnt !== 0) begin err_cnt++; $display("FAIL illegal_writes: got %0d want 0", wr_cnt); end
        pulse_start();
        chk_cnt++; if (error !== 1'b0) begin err_cnt++; $display("FAIL illegal_error_clear: got %b want 0", error); end
    endtask

    task automatic test_overflow();
        int seen_ready;
        do_reset();
        clear_model();
        pulse_start();
        for (int i = 0; i < 899; i++) send_byte(8'hF3);  // 14384 tiles
        send_byte(8'hD3);                                 // 14 more -> 14398
        send_byte(8'h32);                                 // 4-tile run, only 2 fit
        wait_idle(20);
        seen_ready = 0;
        rle_if.data_in  = 8'h11;
        rle_if.valid_in = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rle_if.ready_out) seen_ready++;
        end
        rle_if.valid_in = 1'b0;
        chk_cnt++; if (wr_cnt !== 14400) begin err_cnt++; $display("FAIL ovf_wr_cnt: got %0d want 14400", wr_cnt); end
        chk_cnt++; if (ram_m[14397] !== 4'd3) begin err_cnt++; $display("FAIL ovf_ram_14397: got %0d want 3", ram_m[14397]); end
        chk_cnt++;
        if (ram_m[14398] !== 4'd2 || ram_m[14399] !== 4'd2) begin
            err_cnt++;
            $display("FAIL ovf_ram_tail: got %0d %0d want 2 2", ram_m[14398], ram_m[14399]);
        end
        chk_cnt++; if (error !== 1'b1) begin err_cnt++; $display("FAIL ovf_error: got %b want 1", error); end
        chk_cnt++; if (done_cnt !== 1) begin err_cnt++; $display("FAIL ovf_done_pulses: got %0d want 1", done_cnt); end
        chk_cnt++; if (seen_ready !== 0) begin err_cnt++; $display("FAIL ovf_extra_byte: ready seen %0d cycles want 0", seen_ready); end
    endtask

    task automatic test_backpressure();
        logic [7:0] stream [6];
        logic [3:0] exp_q [$];
        logic [7:0] b;
        int bad;
        int n;
        stream = '{8'h21, 8'h0B, 8'h53, 8'h70, 8'h12, 8'hF4};
        exp_q = {};
        for (int i = 0; i < 6; i++) begin
            b = stream[i];
            for (int k = 0; k <= int'(b[7:4]); k++) exp_q.push_back(b[3:0]);
        end
        do_reset();
        clear_model();
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 3)) begin
                rle_if.valid_in = 1'b0;
                rle_if.data_in  = 8'($urandom);
                @(negedge clk);
            end
            send_byte(stream[i]);
            n = 0;
            while (!rle_if.ready_out && n < 40) begin
                rle_if.data_in  = 8'($urandom);
                rle_if.valid_in = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            rle_if.valid_in = 1'b0;
        end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 36; i++) if (ram_m[i] !== exp_q[i]) bad++;
        chk_cnt++; if (exp_q.size() !== 36) begin err_cnt++; $display("FAIL bp_model_size: got %0d want 36", exp_q.size()); end
        chk_cnt++; if (wr_cnt !== 36) begin err_cnt++; $display("FAIL bp_wr_cnt: got %0d want 36", wr_cnt); end
        chk_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL bp_ram_image: %0d tiles differ, want 0", bad); end
        chk_cnt++; if (ram_m[36] !== 4'hF) begin err_cnt++; $display("FAIL bp_no_extra: ram[36]=%0d want untouched 15", ram_m[36]); end
        chk_cnt++; if (error !== 1'b0 || state_dbg !== ACCEPT) begin err_cnt++; $display("FAIL bp_state: error=%b state=%0d want 0 ACCEPT", error, state_dbg); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        clear_model();
        pulse_start();
        send_byte(8'hF5);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (we !== 1'b0 || busy !== 1'b0 || rle_if.ready_out !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrun_async: we=%b busy=%b ready=%b want 0 0 0", we, busy, rle_if.ready_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_model();
        pulse_start();
        send_byte(8'h17);
        chk_cnt++;
        if (we !== 1'b1 || waddr !== 14'd0 || wdata !== 4'd7) begin
            err_cnt++;
            $display("FAIL midrun_restart: we=%b waddr=%0d wdata=%0d want 1 0 7", we, waddr, wdata);
        end
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (wr_cnt !== 2 || ram_m[0] !== 4'd7 || ram_m[1] !== 4'd7) begin
            err_cnt++;
            $display("FAIL midrun_writes: cnt=%0d ram0=%0d ram1=%0d want 2 7 7", wr_cnt, ram_m[0], ram_m[1]);
        end
    endtask

    initial begin
        rle_if.valid_in = 1'b0;
        rle_if.data_in  = 8'h00;
        test_reset();
        test_basic_run();
        test_illegal_code();
        test_backpressure();
        test_reset_midrun();
        test_full_map();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
